hazard_stall_controller: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS datapath.
- Drives the select of the 9-bit ID-stage control-word mux: 0 = decoded control, 1 = bubble (all zero), 2 = flush word.
- Gates the PC and IF/ID register writes.
- Sequences three hazard types: load-use stalls, multi-cycle MUL/DIV HI/LO interlocks, and taken-branch flushes.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_muldiv_timer.sv | 41 ++++
 rtl/hazard_stall_controller.sv | 122 ++++++++++++
 tb/tb_hazard_stall_controller.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    SEL_CTRL   = 2'd0,
    SEL_BUBBLE = 2'd1,
    SEL_FLUSH  = 2'd2
  } ctrl_sel_e;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MD_CNT_W = 4;
  localparam int FL_CNT_W = 2;

  // Load in EX writes a register the ID instruction reads; $zero never hazards.
  function automatic logic load_use(input logic       mem_read,
                                    input logic [4:0] ex_rd,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt,
                                    input logic       uses_rt);
    return mem_read && (ex_rd != REG_ZERO) &&
           ((ex_rd == rs) || (uses_rt && (ex_rd == rt)));
  endfunction

endpackage

// File: rtl/hazard_muldiv_timer.sv
// HI/LO busy timer: reloads on MUL/DIV issue and counts down to idle.
module hazard_muldiv_timer
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy
);

  localparam logic [MD_CNT_W-1:0] LAT = MD_CNT_W'(MULDIV_LAT);

  logic [MD_CNT_W-1:0] md_cnt_d;
  logic [MD_CNT_W-1:0] md_cnt_q;

  // Next count: reload on issue, otherwise saturating decrement.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (load) begin
      md_cnt_d = LAT;
    end else if (md_cnt_q != {MD_CNT_W{1'b0}}) begin
      md_cnt_d = md_cnt_q - {{(MD_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      md_cnt_d = {MD_CNT_W{1'b0}};
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= {MD_CNT_W{1'b0}};
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign busy = (md_cnt_q != {MD_CNT_W{1'b0}});

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard controller: redirect flushes, load-use and HI/LO stalls.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT   = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRt,
  input  logic       ID_MulDiv,
  input  logic       ID_ReadsHiLo,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_Rd,
  input  logic       EX_BranchTaken,
  output logic       PCWrite,
  output logic       IFID_Write,
  output logic       IFID_Flush,
  output logic [1:0] CtrlSel,
  output logic       Busy
);

  localparam logic [FL_CNT_W-1:0] FL_RELOAD = FL_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [FL_CNT_W-1:0] FL_ONE    = {{(FL_CNT_W-1){1'b0}}, 1'b1};

  state_e              state_d, state_q;
  logic [FL_CNT_W-1:0] fl_cnt_d, fl_cnt_q;

  logic      lu_s, md_s, redirect_s, stall_s, md_load_s, md_busy_s;
  logic      pc_write_s, ifid_write_s, ifid_flush_s;
  ctrl_sel_e ctrl_sel_s;

  hazard_muldiv_timer #(
    .MULDIV_LAT(MULDIV_LAT)
  ) u_md_timer (
    .clk  (Clk),
    .reset(Reset),
    .load (md_load_s),
    .busy (md_busy_s)
  );

  // Hazard detection and output priority: redirect > stall > normal.
  always_comb begin
    lu_s         = load_use(EX_MemRead, EX_Rd, ID_Rs, ID_Rt, ID_UsesRt);
    md_s         = md_busy_s && (ID_ReadsHiLo || ID_MulDiv);
    redirect_s   = EX_BranchTaken || (state_q == FLUSH);
    stall_s      = lu_s || md_s;
    pc_write_s   = 1'b1;
    ifid_write_s = 1'b1;
    ifid_flush_s = 1'b0;
    ctrl_sel_s   = SEL_CTRL;
    if (Reset) begin
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      ifid_flush_s = 1'b0;
      ctrl_sel_s   = SEL_BUBBLE;
    end else if (redirect_s) begin
      pc_write_s   = 1'b1;
      ifid_write_s = 1'b1;
      ifid_flush_s = 1'b1;
      ctrl_sel_s   = SEL_FLUSH;
    end else if (stall_s) begin
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      ifid_flush_s = 1'b0;
      ctrl_sel_s   = SEL_BUBBLE;
    end else begin
      pc_write_s   = 1'b1;
      ifid_write_s = 1'b1;
      ifid_flush_s = 1'b0;
      ctrl_sel_s   = SEL_CTRL;
    end
  end

  // Only an instruction that actually leaves ID starts the HI/LO timer.
  assign md_load_s = ID_MulDiv && !redirect_s && !stall_s && !Reset;

  // Flush sequencing; a new taken branch always reloads the count.
  always_comb begin
    state_d  = state_q;
    fl_cnt_d = fl_cnt_q;
    if (EX_BranchTaken) begin
      fl_cnt_d = FL_RELOAD;
      state_d  = (FL_RELOAD != {FL_CNT_W{1'b0}}) ? FLUSH : RUN;
    end else begin
      case (state_q)
        FLUSH: begin
          fl_cnt_d = fl_cnt_q - FL_ONE;
          state_d  = (fl_cnt_q == FL_ONE) ? RUN : FLUSH;
        end
        RUN: begin
          fl_cnt_d = {FL_CNT_W{1'b0}};
          state_d  = RUN;
        end
        default: begin
          fl_cnt_d = {FL_CNT_W{1'b0}};
          state_d  = RUN;
        end
      endcase
    end
  end

  // Flush state registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= RUN;
      fl_cnt_q <= {FL_CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  assign PCWrite    = pc_write_s;
  assign IFID_Write = ifid_write_s;
  assign IFID_Flush = ifid_flush_s;
  assign CtrlSel    = ctrl_sel_s;
  assign Busy       = md_busy_s && !Reset;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with MULDIV_LAT=4, FLUSH_CYCLES=2.
module tb_hazard_stall_controller;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] ID_Rs, ID_Rt, EX_Rd;
  logic       ID_UsesRt, ID_MulDiv, ID_ReadsHiLo, EX_MemRead, EX_BranchTaken;
  logic       PCWrite, IFID_Write, IFID_Flush, Busy;
  logic [1:0] CtrlSel;

  typedef struct {
    string      tag;
    logic       pcw;
    logic       ifw;
    logic       fl;
    logic [1:0] sel;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  hazard_stall_controller #(.MULDIV_LAT(4), .FLUSH_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_MulDiv(ID_MulDiv), .ID_ReadsHiLo(ID_ReadsHiLo), .EX_MemRead(EX_MemRead),
    .EX_Rd(EX_Rd), .EX_BranchTaken(EX_BranchTaken), .PCWrite(PCWrite),
    .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush), .CtrlSel(CtrlSel), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input string field, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic pcw, input logic ifw,
                            input logic fl, input logic [1:0] sel, input logic busy);
    exp_t e;
    e.tag = tag; e.pcw = pcw; e.ifw = ifw; e.fl = fl; e.sel = sel; e.busy = busy;
    exp_q.push_back(e);
  endtask

  // Compare settled outputs mid-cycle, then advance to just after the next edge.
  task automatic settle_and_compare();
    exp_t e;
    #3;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      check(e.tag, "PCWrite",    int'(PCWrite),    int'(e.pcw));
      check(e.tag, "IFID_Write", int'(IFID_Write), int'(e.ifw));
      check(e.tag, "IFID_Flush", int'(IFID_Flush), int'(e.fl));
      check(e.tag, "CtrlSel",    int'(CtrlSel),    int'(e.sel));
      check(e.tag, "Busy",       int'(Busy),       int'(e.busy));
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic pcw, input logic ifw,
                     input logic fl, input logic [1:0] sel, input logic busy);
    expect_out(tag, pcw, ifw, fl, sel, busy);
    settle_and_compare();
  endtask

  task automatic clear_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; EX_Rd = 5'd0;
    ID_UsesRt = 1'b0; ID_MulDiv = 1'b0; ID_ReadsHiLo = 1'b0;
    EX_MemRead = 1'b0; EX_BranchTaken = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    clear_inputs();
    @(posedge Clk);
    #1;
    cyc("reset", 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    Reset = 1'b0;
    cyc("idle", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);

    // Load-use on rs: one bubble, then resume.
    EX_MemRead = 1'b1; EX_Rd = 5'd8; ID_Rs = 5'd8;
    cyc("lu_rs", 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    EX_MemRead = 1'b0;
    cyc("lu_rs_after", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);

    // $zero destination never hazards.
    EX_MemRead = 1'b1; EX_Rd = 5'd0; ID_Rs = 5'd0;
    cyc("lu_zero", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);

    // rt match only counts when rt is a source.
    EX_Rd = 5'd9; ID_Rt = 5'd9; ID_Rs = 5'd1; ID_UsesRt = 1'b0;
    cyc("lu_rt_unused", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    ID_UsesRt = 1'b1;
    cyc("lu_rt_used", 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    clear_inputs();
    cyc("lu_rt_after", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);

    // MUL/DIV issue then MFHI held: four bubbles.
    ID_MulDiv = 1'b1;
    cyc("md_issue", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    ID_MulDiv = 1'b0; ID_ReadsHiLo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("md_stall%0d", i), 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
    end
    cyc("md_done", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    clear_inputs();

    // Taken branch with a simultaneous load-use: flush wins for two cycles.
    EX_BranchTaken = 1'b1; EX_MemRead = 1'b1; EX_Rd = 5'd8; ID_Rs = 5'd8;
    cyc("br_flush0", 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);
    EX_BranchTaken = 1'b0;
    cyc("br_flush1", 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);
    cyc("br_lu_after", 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    clear_inputs();
    cyc("br_idle", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);

    // Second branch during flush reloads the count.
    EX_BranchTaken = 1'b1;
    cyc("rl_br0", 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);
    cyc("rl_br1", 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);
    EX_BranchTaken = 1'b0;
    cyc("rl_tail", 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);
    cyc("rl_idle", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);

    // Reset in the second interlock cycle aborts the stall.
    ID_MulDiv = 1'b1;
    cyc("rst_md_issue", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    ID_MulDiv = 1'b0; ID_ReadsHiLo = 1'b1;
    cyc("rst_md_stall", 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
    Reset = 1'b1;
    cyc("rst_md_forced", 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    Reset = 1'b0;
    cyc("rst_md_release", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    clear_inputs();

    // Reset mid-flush leaves no residual flush.
    EX_BranchTaken = 1'b1;
    cyc("rst_fl_br", 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);
    EX_BranchTaken = 1'b0; Reset = 1'b1;
    cyc("rst_fl_forced", 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    Reset = 1'b0;
    cyc("rst_fl_release", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
